// File: rtl/fle_param_ccff_if.sv
// Configuration-chain and logic-element signals of one fracturable LUT element.
interface fle_param_ccff_if #(
    parameter int K = 6
);
    logic         ccff_head;
    logic         ccff_en;
    logic         commit;
    logic [K-1:0] fle_in;
    logic         fle_cin;
    logic [1:0]   fle_out;
    logic         fle_cout;
    logic         ccff_tail;
    logic         cfg_valid;
    logic         cmt_err;

    modport master (
        output ccff_head, ccff_en, commit, fle_in, fle_cin,
        input  fle_out, fle_cout, ccff_tail, cfg_valid, cmt_err
    );

    modport slave (
        input  ccff_head, ccff_en, commit, fle_in, fle_cin,
        output fle_out, fle_cout, ccff_tail, cfg_valid, cmt_err
    );
endinterface

// File: rtl/fle_param_ccff.sv
// K-input fracturable LUT with carry logic, programmed through a serial scan
// chain and a shadow register that only takes complete configurations.
module fle_param_ccff #(
    parameter int K = 6
) (
    input  logic             prog_clk,
    input  logic             pReset,
    fle_param_ccff_if.slave  bus
);
    localparam int CFG_W = 2**K + 3;
    localparam int LUT_N = 2**K;
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    logic [CFG_W-1:0] sr;
    logic [CFG_W-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic             cfg_valid;
    logic             cmt_err;
    logic [1:0]       out_q;

    logic [LUT_N-1:0] tt;
    logic             frac;
    logic             carry;
    logic             reg_en;
    logic [K-2:0]     idx;
    logic             a;
    logic             b;
    logic             o0;
    logic             o1;
    logic             cout;
    logic             commit_ok;

    assign tt     = shadow[LUT_N-1:0];
    assign frac   = shadow[LUT_N];
    assign carry  = shadow[LUT_N+1];
    assign reg_en = shadow[LUT_N+2];
    assign idx    = bus.fle_in[K-2:0];

    // Fractured/carry modes read both halves of the table with the top input dropped.
    always_comb begin
        a = tt[bus.fle_in];
        b = 1'b0;
        if (frac || carry) begin
            a = tt[{1'b0, idx}];
            b = tt[{1'b1, idx}];
        end
    end

    assign o0   = carry ? (a ^ bus.fle_cin) : a;
    assign o1   = b;
    assign cout = carry & (a ? bus.fle_cin : b);

    assign commit_ok = bus.commit & ~bus.ccff_en & (cnt == CNT_FULL);

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            sr        <= '0;
            shadow    <= '0;
            cnt       <= '0;
            cfg_valid <= 1'b0;
            cmt_err   <= 1'b0;
            out_q     <= 2'b00;
        end else begin
            cmt_err <= 1'b0;
            out_q   <= cfg_valid ? {o1, o0} : 2'b00;
            if (commit_ok) begin
                shadow    <= sr;
                cfg_valid <= 1'b1;
                cnt       <= '0;
            end else if (bus.commit) begin
                cmt_err <= 1'b1;
            end
            // Any shift invalidates the shadow, even one concurrent with a rejected commit.
            if (bus.ccff_en) begin
                sr        <= {sr[CFG_W-2:0], bus.ccff_head};
                cfg_valid <= 1'b0;
                if (cnt != CNT_FULL) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    // fle_out[0] carries o0 and fle_out[1] carries o1.
    assign bus.fle_out   = cfg_valid ? (reg_en ? out_q : {o1, o0}) : 2'b00;
    assign bus.fle_cout  = cfg_valid & cout;
    assign bus.ccff_tail = sr[CFG_W-1];
    assign bus.cfg_valid = cfg_valid;
    assign bus.cmt_err   = cmt_err;
endmodule

// File: tb/tb_fle_param_ccff.sv
// Scoreboard bench for fle_param_ccff: a bit-queue reference model predicts
// every cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_fle_param_ccff;
    localparam int K     = 6;
    localparam int LUT_N = 2**K;
    localparam int HALF  = LUT_N / 2;
    localparam int CFG_W = LUT_N + 3;

    logic prog_clk = 1'b0;
    logic pReset   = 1'b0;

    fle_param_ccff_if #(.K(K)) bus ();

    fle_param_ccff #(.K(K)) dut (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .bus      (bus)
    );

    always #5 prog_clk = ~prog_clk;

    typedef struct {
        string      name;
        logic [1:0] out;
        logic       cout;
        logic       valid;
        logic       err;
        logic       tail;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    bit       sr_m[$];
    int       cnt_m;
    bit       valid_m;
    bit       err_m;
    bit [1:0] oreg_m;
    bit       tt_m[LUT_N];
    bit       frac_m;
    bit       carry_m;
    bit       regen_m;

    function automatic void model_reset();
        sr_m.delete();
        for (int i = 0; i < CFG_W; i++) sr_m.push_back(1'b0);
        cnt_m   = 0;
        valid_m = 1'b0;
        err_m   = 1'b0;
        oreg_m  = 2'b00;
        for (int i = 0; i < LUT_N; i++) tt_m[i] = 1'b0;
        frac_m  = 1'b0;
        carry_m = 1'b0;
        regen_m = 1'b0;
    endfunction

    // Oldest bit in the queue is the chain MSB, so shadow bit i is sr_m[CFG_W-1-i].
    function automatic void model_capture();
        for (int i = 0; i < LUT_N; i++) tt_m[i] = sr_m[CFG_W-1-i];
        frac_m  = sr_m[CFG_W-1-LUT_N];
        carry_m = sr_m[CFG_W-2-LUT_N];
        regen_m = sr_m[CFG_W-3-LUT_N];
    endfunction

    function automatic void lut_eval(input logic [K-1:0] fin, input logic cin,
                                     output bit o0, output bit o1, output bit co);
        int n;
        bit a;
        bit b;
        n = int'(fin);
        if (!frac_m && !carry_m) begin
            a = tt_m[n];
            b = 1'b0;
        end else begin
            a = tt_m[n % HALF];
            b = tt_m[(n % HALF) + HALF];
        end
        if (carry_m) begin
            o0 = a ^ cin;
            o1 = b;
            co = (a && cin) || (!a && b);
        end else begin
            o0 = a;
            o1 = b;
            co = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic head, input logic en, input logic cmt,
                                 input logic [K-1:0] fin, input logic cin, input string tag);
        exp_t     e;
        bit       o0;
        bit       o1;
        bit       co;
        bit [1:0] comb;
        bit       accept;
        @(posedge prog_clk);
        #1;
        bus.ccff_head = head;
        bus.ccff_en   = en;
        bus.commit    = cmt;
        bus.fle_in    = fin;
        bus.fle_cin   = cin;
        lut_eval(fin, cin, o0, o1, co);
        comb    = {o1, o0};
        e.name  = $sformatf("%s#%0d", tag, step_no);
        e.valid = valid_m;
        e.err   = err_m;
        e.tail  = sr_m[0];
        e.out   = valid_m ? (regen_m ? oreg_m : comb) : 2'b00;
        e.cout  = valid_m ? co : 1'b0;
        sb.push_back(e);
        step_no++;
        oreg_m = valid_m ? comb : 2'b00;
        err_m  = 1'b0;
        accept = cmt && !en && (cnt_m == CFG_W);
        if (accept) begin
            model_capture();
            valid_m = 1'b1;
            cnt_m   = 0;
        end else if (cmt) begin
            err_m = 1'b1;
        end
        if (en) begin
            void'(sr_m.pop_front());
            sr_m.push_back(head);
            if (cnt_m < CFG_W) cnt_m++;
            valid_m = 1'b0;
        end
    endtask

    task automatic check_field(input string n, input logic [1:0] act, input logic [1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", n, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        check_field({e.name, ".fle_out"}, bus.fle_out, e.out);
        check_field({e.name, ".fle_cout"}, {1'b0, bus.fle_cout}, {1'b0, e.cout});
        check_field({e.name, ".cfg_valid"}, {1'b0, bus.cfg_valid}, {1'b0, e.valid});
        check_field({e.name, ".cmt_err"}, {1'b0, bus.cmt_err}, {1'b0, e.err});
        check_field({e.name, ".ccff_tail"}, {1'b0, bus.ccff_tail}, {1'b0, e.tail});
    endtask

    always @(negedge prog_clk) begin
        while (sb.size() > 0) checkOutput(sb.pop_front());
    end

    // Reset lands mid-cycle so the monitor sees the cleared outputs before any clock edge.
    task automatic do_reset(input string tag);
        exp_t e;
        @(posedge prog_clk);
        #3;
        pReset        = 1'b0;
        bus.ccff_en   = 1'b0;
        bus.commit    = 1'b0;
        bus.ccff_head = 1'b0;
        model_reset();
        e.name  = tag;
        e.out   = 2'b00;
        e.cout  = 1'b0;
        e.valid = 1'b0;
        e.err   = 1'b0;
        e.tail  = 1'b0;
        sb.push_back(e);
        @(posedge prog_clk);
        #1;
        pReset = 1'b1;
    endtask

    task automatic idle(input logic cmt, input logic [K-1:0] fin, input logic cin, input string tag);
        applyStimulus(1'b0, 1'b0, cmt, fin, cin, tag);
    endtask

    task automatic shift_range(input logic [CFG_W-1:0] w, input int hi, input int lo, input string tag);
        for (int i = hi; i >= lo; i--) begin
            applyStimulus(w[i], 1'b1, 1'b0, K'($urandom), 1'($urandom_range(0, 1)), tag);
        end
    endtask

    task automatic idle_random(input int n, input string tag);
        for (int i = 0; i < n; i++) idle(1'b0, K'($urandom), 1'($urandom_range(0, 1)), tag);
    endtask

    function automatic logic [CFG_W-1:0] build_cfg(input logic [LUT_N-1:0] t, input logic frac,
                                                   input logic carry, input logic regen);
        return {regen, carry, frac, t};
    endfunction

    logic [LUT_N-1:0] t;
    logic [CFG_W-1:0] cfg;

    initial begin
        bus.ccff_head = 1'b0;
        bus.ccff_en   = 1'b0;
        bus.commit    = 1'b0;
        bus.fle_in    = '0;
        bus.fle_cin   = 1'b0;
        model_reset();
        do_reset("reset");
        idle_random(2, "post_reset");

        t = '0;
        t[LUT_N-1] = 1'b1;
        cfg = build_cfg(t, 1'b0, 1'b0, 1'b0);
        shift_range(cfg, CFG_W-1, 0, "and6_shift");
        idle(1'b1, K'(0), 1'b0, "and6_commit");
        idle(1'b0, 6'h3F, 1'b0, "and6_3F");
        idle(1'b0, 6'h3E, 1'b1, "and6_3E");
        idle_random(10, "and6_rand");

        t = {$urandom, $urandom};
        cfg = build_cfg(t, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        shift_range(cfg, CFG_W-1, 1, "early_shift");
        idle(1'b1, K'($urandom), 1'b0, "early_commit");
        idle(1'b0, K'($urandom), 1'b0, "early_err");
        shift_range(cfg, 0, 0, "early_last");
        idle(1'b1, K'($urandom), 1'b0, "late_commit");
        idle_random(8, "late_rand");

        for (int i = 0; i < LUT_N; i++) begin
            t[i] = (i < HALF) ? (((i % HALF) & 1) != ((i % HALF) >> 1 & 1))
                              : (((i % HALF) & 1) == 1 && ((i % HALF) >> 1 & 1) == 1);
        end
        cfg = build_cfg(t, 1'b0, 1'b1, 1'b0);
        shift_range({CFG_W{1'b1}}, 0, 0, "fa_junk");
        shift_range(cfg, CFG_W-1, 1, "fa_shift");
        applyStimulus(cfg[0], 1'b1, 1'b1, K'(0), 1'b0, "busy_commit");
        idle(1'b1, K'(0), 1'b0, "idle_commit");
        idle(1'b0, 6'h03, 1'b1, "fa_in11_c1");
        idle(1'b0, 6'h01, 1'b1, "fa_in10_c1");
        idle_random(16, "fa_rand");

        t = {$urandom, $urandom};
        cfg = build_cfg(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        shift_range(cfg, CFG_W-1, 0, "reg_shift");
        idle(1'b1, K'($urandom), 1'b0, "reg_commit");
        idle_random(20, "reg_rand");
        do_reset("mid_reset");
        shift_range(cfg, CFG_W-1, 1, "rst_shift");
        idle(1'b1, K'($urandom), 1'b0, "rst_early_commit");
        shift_range(cfg, 0, 0, "rst_last");
        idle(1'b1, K'($urandom), 1'b0, "rst_commit");
        idle_random(6, "rst_rand");

        do_reset("chain_reset");
        for (int i = 0; i < 3 * CFG_W; i++) begin
            applyStimulus((i == 0) || (i >= CFG_W && i < 2 * CFG_W && (i % 2) == 1),
                          1'b1, 1'b0, K'($urandom), 1'b0, "chain");
        end

        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                          $urandom_range(0, 9) == 0, K'($urandom), 1'($urandom_range(0, 1)),
                          "free");
        end

        @(posedge prog_clk);
        @(negedge prog_clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
